cla_pipe: RTL and testbench
===========================

CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 SHALL have parameter DW, default 16: operand/result width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline register stages; legal when 1 <= STAGES and (DW/4) % STAGES == 0.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i, input, 1 bit: operand beat valid.
REQ-006 SHALL have port ready_o, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port a_i, input, DW bits: operand A.
REQ-008 SHALL have port b_i, input, DW bits: operand B.
REQ-009 SHALL have port ci_i, input, 1 bit: carry-in; ignored when sub_i=1.
REQ-010 SHALL have port sub_i, input, 1 bit: 0 = A+B+ci_i, 1 = A-B.
REQ-011 SHALL have port valid_o, output, 1 bit: result valid.
REQ-012 SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port s_o, output, DW bits: sum/difference.
REQ-014 SHALL have port co_o, output, 1 bit: carry-out of the MSB (for sub_i=1, 1 = no borrow).
REQ-015 SHALL have port ovf_o, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL build the datapath from 4-bit carry-lookahead groups (p = a|b, g = a&b, fully expanded group carries), rippling the carry between groups; NBLK = DW/4 groups.
REQ-017 SHALL compute the effective B as b_i ^ {DW{sub_i}} and the effective carry-in as sub_i ? 1 : ci_i, both at input acceptance.
REQ-018 SHALL split the groups into STAGES slices of NBLK/STAGES groups each, slice k processed in stage k (LSB slice first).
REQ-019 SHALL register, per stage, a valid bit, the completed sum bits so far, the inter-slice carry, and the not-yet-processed upper operand bits (skew buffering).
REQ-020 SHALL have a latency of exactly STAGES cycles from an accepted input beat to valid_o=1 when ready_i is held at 1.
REQ-021 SHALL sustain a throughput of one beat per cycle when ready_i=1.
REQ-022 SHALL let stage k load when it is empty or stage k+1 loads this cycle; the last stage SHALL drain when valid_o & ready_i.
REQ-023 SHALL drive ready_o = stage-0 load condition (empty, or stage 0 advancing), combinational from ready_i.
REQ-024 SHALL treat an input beat as accepted only when valid_i & ready_o; otherwise a_i/b_i/ci_i/sub_i are ignored.
REQ-025 SHALL hold s_o, co_o, ovf_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-026 SHALL, when a stage is full and blocked, keep its contents unchanged (no bubble loss, no duplication); results SHALL leave in acceptance order.
REQ-027 SHALL compute ovf_o = carry into MSB XOR carry out of MSB.
REQ-028 SHALL let s_o wrap modulo 2^DW, with the overflowed bit appearing only on co_o.
REQ-029 SHALL, when a beat leaves the last stage and a new one enters stage 0 in the same cycle, perform both transfers.
REQ-030 SHALL, when STAGES=1, act as a single registered stage with latency 1.

Reset
REQ-031 SHALL, on assertion of rst_ni=0, asynchronously clear all stage valid bits, so that valid_o=0 and ready_o=1 follow combinationally.
REQ-032 SHALL also clear s_o, co_o and ovf_o to 0 while rst_ni=0.
REQ-033 SHALL discard in-flight beats on reset mid-operation, with no output after release until new beats are accepted.
REQ-034 SHALL leave datapath registers outside the valid bits unconstrained after reset, but they SHALL never be observable with valid_o=1.

Verification (DW=8, STAGES=2)
REQ-035 SHALL cover: a=0x3C, b=0x45, ci=1, sub=0 -> after 2 cycles s_o=0x82, co_o=0, ovf_o=1.
REQ-036 SHALL cover: a=0x10, b=0x20, sub=1 -> s_o=0xF0, co_o=0, ovf_o=0; and a=0x80, b=0x01, sub=1 -> s_o=0x7F, co_o=1, ovf_o=1.
REQ-037 SHALL cover: a=0xFF, b=0x01, ci=0 -> s_o=0x00, co_o=1, ovf_o=0 (wrap).
REQ-038 SHALL cover: 8 back-to-back beats with ready_i=1 -> 8 consecutive valid_o cycles, in order, starting 2 cycles after the first.
REQ-039 SHALL cover: ready_i=0 for 5 cycles with continuous valid_i -> ready_o falls after 2 beats are held, s_o holds stable, and no beat is lost or duplicated after release.
REQ-040 SHALL cover: rst_ni pulsed low with 2 beats in flight -> valid_o=0 immediately, and no stale output after release.
REQ-041 SHALL cover: random regression against a reference model for DW in {8, 16, 32} and all legal STAGES values.

Source files
------------

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit CLA groups, carry rippled between groups,
// one slice of groups per stage with the upper operand bits skewed along. Valid/ready per stage.
module cla_pipe #(
   parameter int DW     = 16,
   parameter int STAGES = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic          ci_i,
   input  logic          sub_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] s_o,
   output logic          co_o,
   output logic          ovf_o
);

   localparam int NBLK = DW / 4;
   localparam int GPS  = NBLK / STAGES;

   typedef struct packed {
      logic [3:0] s;
      logic       c3;
      logic       c4;
   } grp_t;

   function automatic grp_t cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
      logic [3:0] p, g;
      logic       c1, c2, c3, c4;
      grp_t       r;
      p  = a | b;
      g  = a & b;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      r.s  = a ^ b ^ {c3, c2, c1, c0};
      r.c3 = c3;
      r.c4 = c4;
      return r;
   endfunction

   logic [STAGES-1:0] vld_q, ld, vin;
   logic [STAGES-1:0] c_q, ov_q, c_in, c_nx, ov_nx;
   logic [DW-1:0]     a_q [STAGES];
   logic [DW-1:0]     b_q [STAGES];
   logic [DW-1:0]     s_q [STAGES];
   logic [DW-1:0]     a_in [STAGES];
   logic [DW-1:0]     b_in [STAGES];
   logic [DW-1:0]     s_in [STAGES];
   logic [DW-1:0]     s_nx [STAGES];

   // Stage 0 sees the (already inverted for subtract) operands; later stages see the skew registers.
   for (genvar k = 0; k < STAGES; k++) begin : g_in
      if (k == 0) begin : g_first
         assign a_in[0] = a_i;
         assign b_in[0] = b_i ^ {DW{sub_i}};
         assign c_in[0] = sub_i | ci_i;
         assign s_in[0] = '0;
         assign vin[0]  = valid_i;
      end else begin : g_next
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign s_in[k] = s_q[k-1];
         assign vin[k]  = vld_q[k-1];
      end
   end

   logic [DW-1:0] sx;
   logic          cx, cmx;
   grp_t          rx;

   always_comb begin
      sx  = '0;
      cx  = 1'b0;
      cmx = 1'b0;
      rx  = '0;
      s_nx  = s_in;
      c_nx  = '0;
      ov_nx = '0;
      for (int k = 0; k < STAGES; k++) begin
         sx  = s_in[k];
         cx  = c_in[k];
         cmx = 1'b0;
         for (int g = 0; g < GPS; g++) begin
            rx = cla4(a_in[k][(k*GPS+g)*4 +: 4], b_in[k][(k*GPS+g)*4 +: 4], cx);
            sx[(k*GPS+g)*4 +: 4] = rx.s;
            cmx = rx.c3;
            cx  = rx.c4;
         end
         s_nx[k]  = sx;
         c_nx[k]  = cx;
         // Only the last stage's value is meaningful: there cmx is the carry into the MSB.
         ov_nx[k] = cmx ^ cx;
      end
   end

   // A stage may load if it or any stage downstream of it is empty, or the output drains.
   logic bub;
   always_comb begin
      bub = ready_i;
      ld  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         bub   = bub | ~vld_q[k];
         ld[k] = bub;
      end
   end

   assign ready_o = ld[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         c_q   <= '0;
         ov_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               vld_q[k] <= vin[k];
               a_q[k]   <= a_in[k];
               b_q[k]   <= b_in[k];
               s_q[k]   <= s_nx[k];
               c_q[k]   <= c_nx[k];
               ov_q[k]  <= ov_nx[k];
            end
         end
      end
   end

   assign valid_o = vld_q[STAGES-1];
   assign s_o     = s_q[STAGES-1];
   assign co_o    = c_q[STAGES-1];
   assign ovf_o   = ov_q[STAGES-1];

endmodule

// File: tb/tb_cla_pipe.sv
// Directed and scoreboarded checks of cla_pipe (DW=8/STAGES=2), plus random streams on
// DW=32/STAGES=4 and DW=16/STAGES=1 instances.
module tb_cla_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_i, ready_i, ci, sub;
   logic [7:0] a, b;
   logic       ready_o, valid_o, co, ovf;
   logic [7:0] s;

   logic        v2, ci2, sub2, rdy2;
   logic [31:0] a2, b2;
   logic        r2o, v2o, co2, ov2;
   logic [31:0] s2;
   logic        r3o, v3o, co3, ov3;
   logic [15:0] s3;

   cla_pipe #(.DW(8), .STAGES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a), .b_i(b), .ci_i(ci), .sub_i(sub),
      .valid_o(valid_o), .ready_i(ready_i), .s_o(s), .co_o(co), .ovf_o(ovf));

   cla_pipe #(.DW(32), .STAGES(4)) dut_w32 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(r2o),
      .a_i(a2), .b_i(b2), .ci_i(ci2), .sub_i(sub2),
      .valid_o(v2o), .ready_i(rdy2), .s_o(s2), .co_o(co2), .ovf_o(ov2));

   cla_pipe #(.DW(16), .STAGES(1)) dut_w16 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(r3o),
      .a_i(a2[15:0]), .b_i(b2[15:0]), .ci_i(ci2), .sub_i(sub2),
      .valid_o(v3o), .ready_i(rdy2), .s_o(s3), .co_o(co3), .ovf_o(ov3));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, co, sum} from plain integer arithmetic on a w-bit word.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic sb, input int w);
      logic [63:0] m, yy, sum;
      logic [31:0] r;
      logic        cout, ov;
      m    = (64'd1 << w) - 64'd1;
      yy   = {32'd0, (sb ? ~y : y)} & m;
      sum  = ({32'd0, x} & m) + yy + (sb ? 64'd1 : {63'd0, c});
      r    = sum[31:0] & m[31:0];
      cout = sum[w];
      ov   = (x[w-1] == yy[w-1]) && (r[w-1] != x[w-1]);
      return {ov, cout, r};
   endfunction

   logic [33:0] q[$];
   logic [7:0]  held_s;
   logic        held = 1'b0;

   // One cycle on the main DUT with scoreboarding; entered and left at posedge+1.
   task automatic tick(input logic vin, input logic rin, input logic [7:0] na, input logic [7:0] nb,
                       input logic nci, input logic nsub, output logic rdy_seen);
      logic [33:0] e;
      valid_i = vin; ready_i = rin; a = na; b = nb; ci = nci; sub = nsub;
      @(negedge clk);
      if (held) begin
         check("hold_v", valid_o, 1'b1);
         check("hold_s", s, held_s);
      end
      if (valid_o && ready_i) begin
         check("out_expected", q.size() > 0, 1'b1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_s", s, e[7:0]);
            check("sb_co", co, e[32]);
            check("sb_ovf", ovf, e[33]);
         end
      end
      held     = valid_o && !ready_i;
      held_s   = s;
      rdy_seen = ready_o;
      if (valid_i && ready_o) q.push_back(model({24'd0, a}, {24'd0, b}, ci, sub, 8));
      @(posedge clk); #1;
   endtask

   task automatic single(input logic [7:0] na, input logic [7:0] nb, input logic nci, input logic nsub,
                         input logic [7:0] es, input logic eco, input logic eov, input string tag);
      valid_i = 1'b1; ready_i = 1'b1; a = na; b = nb; ci = nci; sub = nsub;
      @(negedge clk);
      check({tag, "_rdy"}, ready_o, 1'b1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      check({tag, "_v_early"}, valid_o, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_v"}, valid_o, 1'b1);
      check({tag, "_s"}, s, es);
      check({tag, "_co"}, co, eco);
      check({tag, "_ovf"}, ovf, eov);
      @(posedge clk); #1;
   endtask

   logic [33:0] bexp [8];
   logic [33:0] e2 [40];
   logic [33:0] e3 [40];
   logic        rs;
   int          j, k2, k3;

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      v2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0; rdy2 = 1'b1;
      #2;
      check("rst_valid", valid_o, 1'b0);
      check("rst_ready", ready_o, 1'b1);
      check("rst_s", s, 8'h00);
      check("rst_co", co, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_w32_valid", v2o, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      single(8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1, "add_ovf");
      single(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow");
      single(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
      single(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
      single(8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_ci_wrap");
      single(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero");

      // Eight back-to-back beats: outputs in cycles 2..9.
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            valid_i = 1'b1; ready_i = 1'b1;
            a = 8'(c * 37 + 5); b = 8'(c * 19 + 200); ci = c[0]; sub = c[2];
            bexp[c] = model({24'd0, a}, {24'd0, b}, ci, sub, 8);
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk);
         check($sformatf("b2b_v%0d", c), valid_o, (c >= 2 && c < 10));
         if (c >= 2 && c < 10) begin
            check($sformatf("b2b_s%0d", c), s, bexp[c-2][7:0]);
            check($sformatf("b2b_co%0d", c), co, bexp[c-2][32]);
            check($sformatf("b2b_ovf%0d", c), ovf, bexp[c-2][33]);
         end
         @(posedge clk); #1;
      end

      // Backpressure: ready_i low for 5 cycles with continuous valid_i.
      j = 0;
      for (int c = 0; c < 16; c++) begin
         tick(c < 10, c >= 5, 8'(8'hA0 + j * 7), 8'(j * 29 + 3), j[0], j[1], rs);
         if (c < 5) check($sformatf("bp_ready%0d", c), rs, c < 2);
         if (c < 10 && rs) j++;
      end
      check("bp_drained", q.size(), 0);
      check("bp_accepted", j, 7);

      // Reset with two beats in flight.
      tick(1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, rs);
      tick(1'b1, 1'b0, 8'h56, 8'h0F, 1'b1, 1'b0, rs);
      valid_i = 1'b0;
      check("pre_rst_valid", valid_o, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid_o, 1'b0);
      check("mid_rst_ready", ready_o, 1'b1);
      check("mid_rst_s", s, 8'h00);
      q.delete();
      held = 1'b0;
      @(negedge clk); rst_n = 1'b1; ready_i = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_v%0d", c), valid_o, 1'b0);
         @(posedge clk); #1;
      end
      single(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "post_rst_add");

      // Random valid/ready traffic on the main instance.
      for (int c = 0; c < 80; c++)
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs);
      for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, rs);
      check("rand_drained", q.size(), 0);

      // Wider / single-stage configurations on a continuous random stream.
      k2 = 0; k3 = 0;
      for (int c = 0; c < 44; c++) begin
         if (c < 40) begin
            v2 = 1'b1; a2 = $urandom; b2 = $urandom;
            ci2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
            e2[c] = model(a2, b2, ci2, sub2, 32);
            e3[c] = model(a2, b2, ci2, sub2, 16);
         end else begin
            v2 = 1'b0;
         end
         @(negedge clk);
         check($sformatf("w32_v%0d", c), v2o, (c >= 4 && c < 44));
         check($sformatf("w16_v%0d", c), v3o, (c >= 1 && c < 41));
         if (v2o && k2 < 40) begin
            check($sformatf("w32_s%0d", k2), s2, e2[k2][31:0]);
            check($sformatf("w32_cv%0d", k2), {co2, ov2}, {e2[k2][32], e2[k2][33]});
         end
         if (v2o) k2++;
         if (v3o && k3 < 40) begin
            check($sformatf("w16_s%0d", k3), s3, e3[k3][15:0]);
            check($sformatf("w16_cv%0d", k3), {co3, ov3}, {e3[k3][32], e3[k3][33]});
         end
         if (v3o) k3++;
         @(posedge clk); #1;
      end
      check("w32_count", k2, 40);
      check("w16_count", k3, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
